// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL dynamic phase-shift controller.
// The LOCKWAIT state exists only when PLL_PHASE_LOCKWAIT_EN is defined.
package pll_ctrl_pkg;

   // PHASESEL[1:0] codes selecting which PLL output receives the phase step.
   localparam logic [1:0] PHASESEL_CLKOP  = 2'd0;
   localparam logic [1:0] PHASESEL_CLKOS  = 2'd1;
   localparam logic [1:0] PHASESEL_CLKOS2 = 2'd2;
   localparam logic [1:0] PHASESEL_CLKOS3 = 2'd3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      STEP_LO  = 3'd2,
      STEP_HI  = 3'd3,
      FINISH   = 3'd5
`ifdef PLL_PHASE_LOCKWAIT_EN
      ,
      LOCKWAIT = 3'd4
`endif
   } phase_state_e;

   // Map a request channel index onto the PHASESEL pin code.
   function automatic logic [1:0] chan_code(input logic [1:0] idx);
      case (idx)
         2'd0:    chan_code = PHASESEL_CLKOP;
         2'd1:    chan_code = PHASESEL_CLKOS;
         2'd2:    chan_code = PHASESEL_CLKOS2;
         default: chan_code = PHASESEL_CLKOS3;
      endcase
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (PLL LOCK).
module sync_2ff (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; both clear while reset is asserted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_phase_ctrl.sv
// PLL dynamic phase-shift sequencer and lock-qualified downstream reset.
// Optional build macro: PLL_PHASE_LOCKWAIT_EN -- after the last step, wait
// for SETUP_CYCLES+PULSE_CYCLES consecutive locked cycles before done.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a request; ready when lock is synchronised high
// SETUP    | phasesel/phasedir settle before the first step pulse
// STEP_LO  | phasestep held low (first half of a step pulse)
// STEP_HI  | phasestep high (second half); counts off one step at the end
// LOCKWAIT | (macro only) waiting for lock to stay high after stepping
// FINISH   | one-cycle done (with err on reject or abort)
module pll_phase_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int CHANNELS     = 2,
   parameter int STEP_W       = 8,
   parameter int SETUP_CYCLES = 2,
   parameter int PULSE_CYCLES = 4,
   parameter int LOCK_STABLE  = 1024
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_chan,
   input  logic              req_dir,
   input  logic [STEP_W-1:0] req_steps,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              pll_locked,
   output logic [1:0]        pll_phasesel,
   output logic              pll_phasedir,
   output logic              pll_phasestep,
   output logic              sys_resetn
);

   localparam int WAIT_CYCLES = SETUP_CYCLES + PULSE_CYCLES;
   localparam int TMR_W       = $clog2(WAIT_CYCLES + 1);
   localparam int LCNT_W      = $clog2(LOCK_STABLE + 1);

   localparam logic [TMR_W-1:0]  SETUP_LD = TMR_W'(SETUP_CYCLES - 1);
   localparam logic [TMR_W-1:0]  PULSE_LD = TMR_W'(PULSE_CYCLES - 1);
`ifdef PLL_PHASE_LOCKWAIT_EN
   localparam logic [TMR_W-1:0]  WAIT_LD  = TMR_W'(WAIT_CYCLES - 1);
`endif
   localparam logic [LCNT_W-1:0] LOCK_TC  = LCNT_W'(LOCK_STABLE);

   logic                locked_s;
   logic                accept;
   logic                chan_ok;

   phase_state_e        state_q, state_nxt;
   logic [TMR_W-1:0]    tmr_q, tmr_nxt;
   logic [STEP_W-1:0]   steps_q, steps_nxt;
   logic [1:0]          sel_q, sel_nxt;
   logic                dir_q, dir_nxt;
   logic                err_q, err_nxt;
   logic                step_q;

   logic [LCNT_W-1:0]   lock_cnt_q;
   logic                sys_rst_q;

   sync_2ff u_lock_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (pll_locked),
      .q      (locked_s)
   );

   assign chan_ok   = (int'(req_chan) < CHANNELS);
   assign req_ready = (state_q == IDLE) && locked_s;
   assign accept    = req_valid && req_ready;

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FINISH);
   assign err           = (state_q == FINISH) && err_q;
   assign pll_phasesel  = sel_q;
   assign pll_phasedir  = dir_q;
   assign pll_phasestep = step_q;
   assign sys_resetn    = sys_rst_q;

   // FSM state and request context registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         steps_q <= '0;
         sel_q   <= 2'd0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         tmr_q   <= tmr_nxt;
         steps_q <= steps_nxt;
         sel_q   <= sel_nxt;
         dir_q   <= dir_nxt;
         err_q   <= err_nxt;
      end
   end

   // Phasestep is registered from the next state so the PLL pin never
   // sees decode glitches; it lines up exactly with STEP_LO residency.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         step_q <= 1'b1;
      end else begin
         step_q <= (state_nxt != STEP_LO);
      end
   end

   // Next-state logic: timers count down and transition on terminal count.
   always_comb begin
      state_nxt = state_q;
      tmr_nxt   = tmr_q;
      steps_nxt = steps_q;
      sel_nxt   = sel_q;
      dir_nxt   = dir_q;
      err_nxt   = err_q;

      case (state_q)
         IDLE: begin
            err_nxt = 1'b0;
            if (accept) begin
               if (!chan_ok) begin
                  // Rejected channel: leave the PLL select pins untouched.
                  err_nxt   = 1'b1;
                  state_nxt = FINISH;
               end else begin
                  sel_nxt   = chan_code(req_chan);
                  dir_nxt   = req_dir;
                  steps_nxt = req_steps;
                  tmr_nxt   = SETUP_LD;
                  state_nxt = (req_steps == '0) ? FINISH : SETUP;
               end
            end
         end

         SETUP: begin
            if (!locked_s) begin
               err_nxt   = 1'b1;
               state_nxt = FINISH;
            end else if (tmr_q == '0) begin
               tmr_nxt   = PULSE_LD;
               state_nxt = STEP_LO;
            end else begin
               tmr_nxt = tmr_q - TMR_W'(1);
            end
         end

         STEP_LO: begin
            if (!locked_s) begin
               err_nxt   = 1'b1;
               state_nxt = FINISH;
            end else if (tmr_q == '0) begin
               tmr_nxt   = PULSE_LD;
               state_nxt = STEP_HI;
            end else begin
               tmr_nxt = tmr_q - TMR_W'(1);
            end
         end

         STEP_HI: begin
            if (!locked_s) begin
               err_nxt   = 1'b1;
               state_nxt = FINISH;
            end else if (tmr_q == '0) begin
               steps_nxt = steps_q - STEP_W'(1);
               if (steps_q == STEP_W'(1)) begin
`ifdef PLL_PHASE_LOCKWAIT_EN
                  tmr_nxt   = WAIT_LD;
                  state_nxt = LOCKWAIT;
`else
                  state_nxt = FINISH;
`endif
               end else begin
                  tmr_nxt   = PULSE_LD;
                  state_nxt = STEP_LO;
               end
            end else begin
               tmr_nxt = tmr_q - TMR_W'(1);
            end
         end

`ifdef PLL_PHASE_LOCKWAIT_EN
         LOCKWAIT: begin
            // A lock dropout restarts the stability window rather than aborting.
            if (!locked_s) begin
               tmr_nxt = WAIT_LD;
            end else if (tmr_q == '0) begin
               state_nxt = FINISH;
            end else begin
               tmr_nxt = tmr_q - TMR_W'(1);
            end
         end
`endif

         FINISH: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Saturating lock-stability counter; any unlocked cycle restarts it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_cnt_q <= '0;
         sys_rst_q  <= 1'b0;
      end else begin
         if (!locked_s) begin
            lock_cnt_q <= '0;
         end else if (lock_cnt_q != LOCK_TC) begin
            lock_cnt_q <= lock_cnt_q + LCNT_W'(1);
         end
         sys_rst_q <= locked_s && (lock_cnt_q == LOCK_TC);
      end
   end

endmodule
